lpc_ior_cpld_reg: RTL

- LPC I/O-read responder for the CPLD register window 0x0800–0x081F. It is the read-side counterpart of the CPLD write-register block.
- Returns registered read data for the write-side register images it is given.
- Holds a read-to-clear sticky event register fed by asynchronous board event inputs, plus a live status view and a version byte.
- Sits beside the write-register block under MR_Bsp and feeds the LPC slave's read-data return path.

---
 rtl/lpc_cpld_pkg.sv | 25 ++
 rtl/lpc_evt_latch.sv | 45 ++++
 rtl/lpc_ior_cpld_reg.sv | 116 +++++++++++
 3 files changed

// File: rtl/lpc_cpld_pkg.sv
// Shared CPLD LPC register-window constants: window base, register offsets, read FSM states.
// Used by both the write-register block and the read responder so the map lives in one place.
package lpc_cpld_pkg;

  localparam logic [10:0] WIN_BASE    = 11'h040;

  localparam logic [4:0]  OFF_BIOS    = 5'h01;
  localparam logic [4:0]  OFF_SYSOK   = 5'h08;
  localparam logic [4:0]  OFF_PSUFAN  = 5'h0A;
  localparam logic [4:0]  OFF_7SEGSEL = 5'h0E;
  localparam logic [4:0]  OFF_7SEGVAL = 5'h0F;
  localparam logic [4:0]  OFF_EVT     = 5'h10;
  localparam logic [4:0]  OFF_EVTRAW  = 5'h12;
  localparam logic [4:0]  OFF_SPCMD   = 5'h18;
  localparam logic [4:0]  OFF_FANLED  = 5'h1B;
  localparam logic [4:0]  OFF_RSTDEV  = 5'h1E;
  localparam logic [4:0]  OFF_VER     = 5'h1F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } rd_state_t;

endpackage

// File: rtl/lpc_evt_latch.sv
// Board event capture: 2-flop synchroniser, rising-edge detect, sticky bits with a clear mask.
// Sticky bit and irq update 3 edges after an input rise; a rise in the same edge as a clear wins.
module lpc_evt_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] evt_in,
  input  logic [W-1:0] clr_mask,
  output logic [W-1:0] evt_sync,
  output logic [W-1:0] evt_sticky,
  output logic         evt_irq
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;
  logic [W-1:0] rise;
  logic [W-1:0] sticky_nxt;
  logic [2:0]   arm;

  // Edge detect stays blind until the pipeline has refilled, so levels present at reset release are ignored.
  always_comb begin
    rise       = evt_sync & ~prev & {W{arm[2]}};
    sticky_nxt = (evt_sticky & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= '0;
      evt_sync   <= '0;
      prev       <= '0;
      arm        <= '0;
      evt_sticky <= '0;
      evt_irq    <= 1'b0;
    end else begin
      meta       <= evt_in;
      evt_sync   <= meta;
      prev       <= evt_sync;
      arm        <= {arm[1:0], 1'b1};
      evt_sticky <= sticky_nxt;
      evt_irq    <= |sticky_nxt;
    end
  end

endmodule

// File: rtl/lpc_ior_cpld_reg.sv
// LPC I/O-read responder for CPLD window 0x0800-0x081F; data/valid registered 2 edges after a sampled hit.
// Valid is held until RdDev_En drops; a held request never re-reads; offset 0x10 is read-to-clear.
module lpc_ior_cpld_reg
  import lpc_cpld_pkg::*;
#(
  parameter logic [7:0] CPLD_VER   = 8'h01,
  parameter int         EVT_W      = 8,
  parameter logic [7:0] RD_DEFAULT = 8'hFF
) (
  input  logic             Mclk,
  input  logic             ResetN,
  input  logic [15:0]      DevAddr,
  input  logic             RdDev_En,
  output logic [7:0]       RdDev_Data,
  output logic             RdDev_Valid,
  input  logic [7:0]       BiosRegister,
  input  logic             SystemOK,
  input  logic [7:0]       PSUFan_StReg,
  input  logic [4:0]       x7SegSel,
  input  logic [7:0]       x7SegVal,
  input  logic [7:0]       SpecialCmdReg,
  input  logic [3:0]       FanLedCtrlReg,
  input  logic [5:0]       ResetDevReg,
  input  logic [EVT_W-1:0] EvtIn,
  output logic             EvtIrq
);

  rd_state_t        state, state_nxt;
  logic [4:0]       rd_off, rd_off_nxt;
  logic [7:0]       data_nxt;
  logic [7:0]       rd_mux;
  logic             valid_nxt;
  logic             hit;
  logic [EVT_W-1:0] evt_sync;
  logic [EVT_W-1:0] evt_sticky;
  logic [EVT_W-1:0] clr_mask;

  assign hit = RdDev_En && (DevAddr[15:5] == WIN_BASE);

  lpc_evt_latch #(.W(EVT_W)) u_evt (
    .clk        (Mclk),
    .rst_n      (ResetN),
    .evt_in     (EvtIn),
    .clr_mask   (clr_mask),
    .evt_sync   (evt_sync),
    .evt_sticky (evt_sticky),
    .evt_irq    (EvtIrq)
  );

  always_comb begin
    rd_mux = RD_DEFAULT;
    case (rd_off)
      OFF_BIOS:    rd_mux = BiosRegister;
      OFF_SYSOK:   rd_mux = {1'b0, SystemOK, 6'b0};
      OFF_PSUFAN:  rd_mux = PSUFan_StReg;
      OFF_7SEGSEL: rd_mux = {3'b0, x7SegSel};
      OFF_7SEGVAL: rd_mux = x7SegVal;
      OFF_EVT:     rd_mux = 8'(evt_sticky);
      OFF_EVTRAW:  rd_mux = 8'(evt_sync);
      OFF_SPCMD:   rd_mux = SpecialCmdReg;
      OFF_FANLED:  rd_mux = {4'b0, FanLedCtrlReg};
      OFF_RSTDEV:  rd_mux = {2'b0, ResetDevReg};
      OFF_VER:     rd_mux = CPLD_VER;
      default:     rd_mux = RD_DEFAULT;
    endcase
  end

  always_ff @(posedge Mclk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      rd_off      <= '0;
      RdDev_Data  <= 8'h00;
      RdDev_Valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_off      <= rd_off_nxt;
      RdDev_Data  <= data_nxt;
      RdDev_Valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (!RdDev_En) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the bits actually returned to the host are cleared; later rises survive via the latch's OR.
  always_comb begin
    rd_off_nxt = rd_off;
    data_nxt   = RdDev_Data;
    valid_nxt  = RdDev_Valid;
    clr_mask   = '0;
    case (state)
      IDLE: begin
        if (hit) rd_off_nxt = DevAddr[4:0];
      end
      CAPTURE: begin
        data_nxt  = rd_mux;
        valid_nxt = 1'b1;
        if (rd_off == OFF_EVT) clr_mask = evt_sticky;
      end
      HOLD: begin
        if (!RdDev_En) valid_nxt = 1'b0;
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
